// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: FSM state encodings, header constants, protocol numbers.
package ip_pkg;

    typedef logic [1:0] ip_state_t;

    localparam ip_state_t ST_IDLE = 2'd0;
    localparam ip_state_t ST_HDR  = 2'd1;
    localparam ip_state_t ST_PAY  = 2'd2;
    localparam ip_state_t ST_DONE = 2'd3;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IPV4_MIN_IHL = 4'd5;

    localparam logic [7:0] PROTO_TCP = 8'd6;
    localparam logic [7:0] PROTO_UDP = 8'd17;

endpackage

// File: rtl/ip_checksum_acc.sv
// 16-bit ones-complement accumulator with end-around carry.
// clr has priority over add; sum is the running registered total.
module ip_checksum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] sum
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;
    logic [16:0] raw;

    // Next sum: fold the carry of the 17-bit add back into bit 0.
    always_comb begin
        raw   = {1'b0, sum_q} + {1'b0, word};
        sum_d = sum_q;
        if (clr) begin
            sum_d = 16'd0;
        end else if (add) begin
            sum_d = raw[15:0] + {15'd0, raw[16]};
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 16'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/ipv4_decode.sv
// IPv4 header parser: latches header fields, verifies the header checksum and
// forwards only the IP payload bytes (Ethernet padding dropped).
// Optional build macro DST_ADDR_FILTER_EN: drop payload of packets not addressed
// to LOCAL_IP or broadcast, and report the result on addr_match.
//
// state   | meaning
// IDLE    | waiting for a burst; only starts once valid has been seen low
// HDR     | sampling header bytes, accumulating checksum
// PAY     | forwarding payload bytes, dropping padding
// DONE    | burst ended; a new valid here starts the next packet
module ipv4_decode
    import ip_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP      = 32'hC0A800C7,
    parameter int unsigned MAX_TOTAL_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  din,
    output logic [31:0] src_addr,
    output logic [31:0] dst_addr,
    output logic [3:0]  ihl,
    output logic [15:0] total_length,
    output logic [7:0]  protocol,
    output logic [7:0]  ttl,
    output logic        hdr_done,
    output logic        payload_valid,
    output logic [7:0]  payload,
    output logic        err,
`ifdef DST_ADDR_FILTER_EN
    output logic        addr_match,
`endif
    output logic        done
);

    ip_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  vihl_q, vihl_d;
    logic [15:0] tlen_q, tlen_d;
    logic [7:0]  ttl_q, ttl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic        hdr_pend_q, hdr_pend_d;
    logic        hdr_done_q, hdr_done_d;
    logic        pay_v_q, pay_v_d;
    logic [7:0]  pay_q, pay_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        armed_q, armed_d;

    logic        acc_clr, acc_add;
    logic [15:0] acc_word, acc_sum;
    logic [15:0] hdr_bytes, hdr_len;
    logic        hdr_bad, addr_ok, start;

    ip_checksum_acc u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (acc_add),
        .word (acc_word),
        .sum  (acc_sum)
    );

    assign acc_word  = {shift_q[7:0], din};
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign hdr_bytes = {10'd0, vihl_q[3:0], 2'b00};
    // An undersized IHL would end the header before the addresses; parse the
    // fixed 20 bytes instead and let hdr_bad flag the packet.
    assign hdr_len   = (vihl_q[3:0] < IPV4_MIN_IHL) ? 16'd20 : hdr_bytes;
    assign hdr_bad   = (acc_sum != 16'hFFFF)
                     || (vihl_q[7:4] != IPV4_VERSION)
                     || (vihl_q[3:0] < IPV4_MIN_IHL)
                     || (tlen_q < hdr_bytes)
                     || ({16'd0, tlen_q} > MAX_TOTAL_LEN);
    assign start     = valid && ((state_q == ST_DONE) || ((state_q == ST_IDLE) && armed_q));

`ifdef DST_ADDR_FILTER_EN
    logic match_q, match_d;
    assign addr_ok = (dst_q == LOCAL_IP) || (dst_q == 32'hFFFFFFFF);
`else
    logic [31:0] unused_local_ip;
    assign unused_local_ip = LOCAL_IP;
    assign addr_ok = 1'b1;
`endif

    // Packet FSM: header sampling, field latching, payload gating and error tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        vihl_d     = vihl_q;
        tlen_d     = tlen_q;
        ttl_d      = ttl_q;
        proto_d    = proto_q;
        src_d      = src_q;
        dst_d      = dst_q;
        hdr_pend_d = hdr_pend_q;
        hdr_done_d = 1'b0;
        pay_v_d    = 1'b0;
        pay_d      = pay_q;
        err_d      = err_q;
        done_d     = 1'b0;
        armed_d    = armed_q | ~valid;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
`ifdef DST_ADDR_FILTER_EN
        match_d    = match_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    cnt_d      = 16'd1;
                    vihl_d     = din;
                    shift_d    = {shift_q[15:0], din};
                    err_d      = 1'b0;
                    hdr_pend_d = 1'b0;
                    acc_clr    = 1'b1;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (valid) begin
                    shift_d = {shift_q[15:0], din};
                    cnt_d   = cnt_inc;
                    acc_add = cnt_q[0];
                    case (cnt_inc)
                        16'd4:   tlen_d  = {shift_q[7:0], din};
                        16'd9:   ttl_d   = din;
                        16'd10:  proto_d = din;
                        16'd16:  src_d   = {shift_q[23:0], din};
                        16'd20:  dst_d   = {shift_q[23:0], din};
                        default: ;
                    endcase
                    if (cnt_inc == hdr_len) begin
                        state_d    = ST_PAY;
                        hdr_pend_d = 1'b1;
                    end
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_PAY: begin
                if (hdr_pend_q) begin
                    hdr_pend_d = 1'b0;
                    hdr_done_d = 1'b1;
                    err_d      = err_q | hdr_bad;
`ifdef DST_ADDR_FILTER_EN
                    match_d    = addr_ok;
`endif
                end
                if (valid) begin
                    cnt_d = cnt_inc;
                    if ((cnt_q < tlen_q) && !err_q && !hdr_bad && addr_ok) begin
                        pay_v_d = 1'b1;
                        pay_d   = din;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (cnt_q < tlen_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            shift_q    <= 24'd0;
            vihl_q     <= 8'd0;
            tlen_q     <= 16'd0;
            ttl_q      <= 8'd0;
            proto_q    <= 8'd0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            hdr_pend_q <= 1'b0;
            hdr_done_q <= 1'b0;
            pay_v_q    <= 1'b0;
            pay_q      <= 8'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            vihl_q     <= vihl_d;
            tlen_q     <= tlen_d;
            ttl_q      <= ttl_d;
            proto_q    <= proto_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            hdr_pend_q <= hdr_pend_d;
            hdr_done_q <= hdr_done_d;
            pay_v_q    <= pay_v_d;
            pay_q      <= pay_d;
            err_q      <= err_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
        end
    end

`ifdef DST_ADDR_FILTER_EN
    // Address match flag, valid from hdr_done onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end
    assign addr_match = match_q;
`endif

    assign src_addr      = src_q;
    assign dst_addr      = dst_q;
    assign ihl           = vihl_q[3:0];
    assign total_length  = tlen_q;
    assign protocol      = proto_q;
    assign ttl           = ttl_q;
    assign hdr_done      = hdr_done_q;
    assign payload_valid = pay_v_q;
    assign payload       = pay_q;
    assign err           = err_q;
    assign done          = done_q;

endmodule
